// File: rtl/alu_mult_sequencer.sv
// Shift-and-add multiply sequencer that borrows the shared EX-stage ALU adder.
// Returns the low WIDTH bits of A*B after a fixed WIDTH-iteration run.
//   state | meaning
//   IDLE  | waiting for Start, ALU operands parked at zero
//   RUN   | one add/shift iteration per clock, Busy high
//   DONE  | one-cycle Done pulse; Start here begins the next multiply
module alu_mult_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] Multiplicand,
  input  logic [WIDTH-1:0] Multiplier,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Product,
  output logic [WIDTH-1:0] AluOperand1,
  output logic [WIDTH-1:0] AluOperand2,
  output logic [1:0]       AluControl,
  input  logic [WIDTH-1:0] AluResult
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [1:0]       ALU_ADD  = 2'b10;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] count;
  logic             accept;
  logic             last_iter;

  // Start is only honoured outside RUN; a request mid-run is dropped.
  assign accept    = Start && (state != RUN);
  assign last_iter = (state == RUN) && (count == LAST_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    AluOperand1 = '0;
    AluOperand2 = '0;
    AluControl  = ALU_ADD;
    case (state)
      IDLE: if (accept) state_nxt = RUN;
      RUN: begin
        AluOperand1 = acc;
        AluOperand2 = mplier[0] ? mcand : '0;
        if (last_iter) state_nxt = DONE;
      end
      DONE: state_nxt = accept ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      count   <= '0;
      Product <= '0;
    end else if (accept) begin
      acc    <= '0;
      mcand  <= Multiplicand;
      mplier <= Multiplier;
      count  <= '0;
    end else if (state == RUN) begin
      acc    <= AluResult;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
      if (last_iter) Product <= AluResult;
    end
  end

  assign Busy = (state == RUN);
  assign Done = (state == DONE);

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Self-checking bench for alu_mult_sequencer with a behavioural ALU adder
// and a queue of expected products pushed at each accepted Start.
module tb_alu_mult_sequencer;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product;
  logic [WIDTH-1:0] alu_op1;
  logic [WIDTH-1:0] alu_op2;
  logic [1:0]       alu_control;
  logic [WIDTH-1:0] alu_result;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  always #5 clk = ~clk;

  // Shared ALU: only the ADD function matters here.
  assign alu_result = (alu_control == 2'b10) ? alu_op1 + alu_op2 : '0;

  alu_mult_sequencer #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .Start        (start),
    .Multiplicand (multiplicand),
    .Multiplier   (multiplier),
    .Busy         (busy),
    .Done         (done),
    .Product      (product),
    .AluOperand1  (alu_op1),
    .AluOperand2  (alu_op2),
    .AluControl   (alu_control),
    .AluResult    (alu_result)
  );

  // Called at a negedge: present a request for one edge, then scramble operands.
  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    start        = 1'b1;
    multiplicand = a;
    multiplier   = b;
    exp_q.push_back(a * b);
    @(posedge clk);
    #1;
    start        = 1'b0;
    multiplicand = $urandom;
    multiplier   = $urandom;
  endtask

  task automatic wait_done(output int cyc, output int busy_n, output int ctl_bad,
                           output int op2_nz, output bit timeout);
    cyc = 0; busy_n = 0; ctl_bad = 0; op2_nz = 0; timeout = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_n++;
      if (alu_control !== 2'b10) ctl_bad++;
      if (busy && alu_op2 !== '0) op2_nz++;
      if (done) begin
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; multiplicand = '0; multiplier = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b product=%h, want 0 0 0", busy, done, product);
    end
    checks++;
    if (alu_op1 !== '0 || alu_op2 !== '0 || alu_control !== 2'b10) begin
      errors++;
      $display("FAIL reset_alu: op1=%h op2=%h ctl=%b, want 0 0 10", alu_op1, alu_op2, alu_control);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int cyc, busy_n, ctl_bad, op2_nz;
    bit to;
    logic [WIDTH-1:0] exp;
    start_op(32'd3, 32'd5);
    wait_done(cyc, busy_n, ctl_bad, op2_nz, to);
    checks++;
    if (to || cyc != 33) begin
      errors++;
      $display("FAIL basic_latency: done at cycle %0d (timeout=%0d), want 33", cyc, to);
    end
    checks++;
    if (busy_n != 32) begin
      errors++;
      $display("FAIL basic_busy: busy cycles %0d, want 32", busy_n);
    end
    checks++;
    if (ctl_bad != 0) begin
      errors++;
      $display("FAIL basic_aluctl: %0d cycles with AluControl != 10, want 0", ctl_bad);
    end
    exp = exp_q.pop_front();
    checks++;
    if (product !== exp) begin
      errors++;
      $display("FAIL basic_product: got %h, want %h", product, exp);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse: done=%b busy=%b after pulse, want 0 0", done, busy);
    end
  endtask

  task automatic test_signed;
    int cyc, busy_n, ctl_bad, op2_nz;
    bit to;
    logic [WIDTH-1:0] exp;
    logic [WIDTH-1:0] a_tab[2] = '{32'hFFFFFFFF, 32'hFFFFFFFD};
    logic [WIDTH-1:0] b_tab[2] = '{32'hFFFFFFFF, 32'd7};
    logic [WIDTH-1:0] r_tab[2] = '{32'h00000001, 32'hFFFFFFEB};
    for (int i = 0; i < 2; i++) begin
      start_op(a_tab[i], b_tab[i]);
      wait_done(cyc, busy_n, ctl_bad, op2_nz, to);
      exp = exp_q.pop_front();
      checks++;
      if (to || product !== exp || product !== r_tab[i]) begin
        errors++;
        $display("FAIL signed_product[%0d]: got %h (timeout=%0d), want %h", i, product, to, r_tab[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_zero;
    int cyc, busy_n, ctl_bad, op2_nz;
    bit to;
    logic [WIDTH-1:0] exp;
    start_op(32'h12345678, 32'd0);
    wait_done(cyc, busy_n, ctl_bad, op2_nz, to);
    exp = exp_q.pop_front();
    checks++;
    if (to || product !== exp) begin
      errors++;
      $display("FAIL zero_b_product: got %h (timeout=%0d), want %h", product, to, exp);
    end
    checks++;
    if (op2_nz != 0) begin
      errors++;
      $display("FAIL zero_b_op2: %0d RUN cycles with nonzero AluOperand2, want 0", op2_nz);
    end
    @(negedge clk);
    start_op(32'd0, 32'hDEADBEEF);
    wait_done(cyc, busy_n, ctl_bad, op2_nz, to);
    exp = exp_q.pop_front();
    checks++;
    if (to || product !== exp) begin
      errors++;
      $display("FAIL zero_a_product: got %h (timeout=%0d), want %h", product, to, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_start_in_run;
    int n_done = 0;
    int late_busy = 0;
    logic [WIDTH-1:0] got = '0;
    logic [WIDTH-1:0] exp;
    start_op(32'd6, 32'd7);
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        got = product;
      end
      if (n_done > 0 && busy) late_busy++;
      if (c == 10) begin
        start = 1'b1; multiplicand = 32'd9; multiplier = 32'd9;
      end else if (c == 11) begin
        start = 1'b0;
      end
    end
    exp = exp_q.pop_front();
    checks++;
    if (n_done != 1) begin
      errors++;
      $display("FAIL run_start_dones: %0d Done pulses, want 1", n_done);
    end
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL run_start_product: got %h, want %h", got, exp);
    end
    checks++;
    if (late_busy != 0) begin
      errors++;
      $display("FAIL run_start_requeue: busy for %0d cycles after Done, want 0", late_busy);
    end
  endtask

  task automatic test_back_to_back;
    int cyc, busy_n, ctl_bad, op2_nz;
    bit to;
    logic [WIDTH-1:0] exp;
    start_op(32'd6, 32'd7);
    wait_done(cyc, busy_n, ctl_bad, op2_nz, to);
    exp = exp_q.pop_front();
    checks++;
    if (to || product !== exp || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: product=%h busy=%b (timeout=%0d), want %h busy=0", product, busy, to, exp);
    end
    start_op(32'd10, 32'd11);
    wait_done(cyc, busy_n, ctl_bad, op2_nz, to);
    exp = exp_q.pop_front();
    checks++;
    if (to || cyc != 33) begin
      errors++;
      $display("FAIL b2b_latency: second done at cycle %0d (timeout=%0d), want 33", cyc, to);
    end
    checks++;
    if (product !== exp) begin
      errors++;
      $display("FAIL b2b_second: got %h, want %h", product, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset;
    int cyc, busy_n, ctl_bad, op2_nz;
    int n_done = 0;
    bit to;
    logic [WIDTH-1:0] exp;
    start_op(32'd100, 32'd3);
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
      errors++;
      $display("FAIL async_reset: busy=%b done=%b product=%h, want 0 0 0", busy, done, product);
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    checks++;
    if (n_done != 0) begin
      errors++;
      $display("FAIL async_reset_idle: %0d cycles busy/done after reset, want 0", n_done);
    end
    start_op(32'd4, 32'd4);
    wait_done(cyc, busy_n, ctl_bad, op2_nz, to);
    exp = exp_q.pop_front();
    checks++;
    if (to || product !== exp) begin
      errors++;
      $display("FAIL async_reset_fresh: got %h (timeout=%0d), want %h", product, to, exp);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_zero();
    test_start_in_run();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
